// File: rtl/ps2_scan_ctrl.sv
// Host-side sequencer for the PS2 receiver: arms it, polls status, fetches bytes,
// folds E0/F0 prefixes into key events and queues them in a fall-through FIFO.
module ps2_scan_ctrl #(
   parameter int POLL_DIV   = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        i_Clk,
   input  logic        i_Rst,
   input  logic        i_Enable,
   output logic        o_WEnable,
   output logic [31:0] o_WAddr,
   output logic [31:0] o_WData,
   output logic        o_REnable,
   output logic [31:0] o_RAddr,
   input  logic [31:0] i_RData,
   input  logic        i_Err,
   output logic        o_EvtValid,
   output logic [9:0]  o_EvtData,
   input  logic        i_EvtReady,
   output logic        o_Overflow,
   input  logic        i_ClrOvf,
   output logic [7:0]  o_ErrCount,
   output logic        o_Busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
   localparam logic [31:0] ADDR_CTRL   = 32'h0;
   localparam logic [31:0] ADDR_STATUS = 32'h4;
   localparam logic [31:0] ADDR_DATA   = 32'h8;

   typedef enum logic [3:0] {
      S_IDLE, S_ARM, S_WAIT, S_POLL, S_POLL_W, S_FETCH,
      S_FETCH_W, S_DECODE, S_ERR_DIS, S_ERR_EN, S_DIS
   } state_t;

   state_t          state_reg;
   logic [CW-1:0]   poll_cnt_reg;
   logic [7:0]      byte_reg;
   logic            ext_reg;
   logic            rel_reg;

   logic            push;
   logic            pop;
   logic            full;
   logic            empty;
   logic [9:0]      evt_next;
   logic [AW:0]     wr_ptr_reg;
   logic [AW:0]     rd_ptr_reg;
   logic [9:0]      mem [FIFO_DEPTH];

   logic unused_rdata;
   assign unused_rdata = &{1'b0, i_RData[31:8]};

   assign o_Busy = (state_reg != S_IDLE);

   // Strobes are registered on the transition, so they are high exactly while
   // the FSM sits in the access state; read data is taken in the following state.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_reg    <= S_IDLE;
         poll_cnt_reg <= '0;
         byte_reg     <= '0;
         ext_reg      <= 1'b0;
         rel_reg      <= 1'b0;
         o_ErrCount   <= '0;
         o_WEnable    <= 1'b0;
         o_WAddr      <= '0;
         o_WData      <= '0;
         o_REnable    <= 1'b0;
         o_RAddr      <= '0;
      end else begin
         o_WEnable <= 1'b0;
         o_WAddr   <= '0;
         o_WData   <= '0;
         o_REnable <= 1'b0;
         o_RAddr   <= '0;
         case (state_reg)
            S_IDLE: begin
               if (i_Enable) begin
                  state_reg <= S_ARM;
                  o_WEnable <= 1'b1;
                  o_WAddr   <= ADDR_CTRL;
                  o_WData   <= 32'd1;
               end
            end
            S_ARM: begin
               state_reg    <= S_WAIT;
               poll_cnt_reg <= '0;
            end
            S_WAIT: begin
               if (!i_Enable) begin
                  state_reg <= S_DIS;
                  o_WEnable <= 1'b1;
                  o_WAddr   <= ADDR_CTRL;
               end else if (poll_cnt_reg == CW'(POLL_DIV - 1)) begin
                  state_reg <= S_POLL;
                  o_REnable <= 1'b1;
                  o_RAddr   <= ADDR_STATUS;
               end else begin
                  poll_cnt_reg <= poll_cnt_reg + 1'b1;
               end
            end
            S_POLL: state_reg <= S_POLL_W;
            S_POLL_W: begin
               if (!i_Enable) begin
                  state_reg <= S_DIS;
                  o_WEnable <= 1'b1;
                  o_WAddr   <= ADDR_CTRL;
               end else if (i_RData[1] || i_Err) begin
                  state_reg <= S_ERR_DIS;
                  o_WEnable <= 1'b1;
                  o_WAddr   <= ADDR_CTRL;
               end else if (i_RData[0]) begin
                  state_reg <= S_FETCH;
                  o_REnable <= 1'b1;
                  o_RAddr   <= ADDR_DATA;
               end else begin
                  state_reg    <= S_WAIT;
                  poll_cnt_reg <= '0;
               end
            end
            S_FETCH: state_reg <= S_FETCH_W;
            S_FETCH_W: begin
               byte_reg  <= i_RData[7:0];
               state_reg <= S_DECODE;
            end
            S_DECODE: begin
               if (byte_reg == 8'hE0) begin
                  ext_reg <= 1'b1;
               end else if (byte_reg == 8'hF0) begin
                  rel_reg <= 1'b1;
               end else begin
                  ext_reg <= 1'b0;
                  rel_reg <= 1'b0;
               end
               state_reg    <= S_WAIT;
               poll_cnt_reg <= '0;
            end
            S_ERR_DIS: begin
               ext_reg <= 1'b0;
               rel_reg <= 1'b0;
               if (o_ErrCount != 8'hFF) o_ErrCount <= o_ErrCount + 1'b1;
               state_reg <= S_ERR_EN;
               o_WEnable <= 1'b1;
               o_WAddr   <= ADDR_CTRL;
               o_WData   <= 32'd1;
            end
            S_ERR_EN: begin
               state_reg    <= S_WAIT;
               poll_cnt_reg <= '0;
            end
            S_DIS: begin
               ext_reg   <= 1'b0;
               rel_reg   <= 1'b0;
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // Event FIFO: pointers carry one extra wrap bit to tell full from empty.
   assign push     = (state_reg == S_DECODE) && (byte_reg != 8'hE0) && (byte_reg != 8'hF0);
   assign evt_next = {rel_reg, ext_reg, byte_reg};
   assign empty    = (wr_ptr_reg == rd_ptr_reg);
   assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign pop      = !empty && i_EvtReady;

   assign o_EvtValid = !empty;
   assign o_EvtData  = empty ? 10'd0 : mem[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge i_Clk) begin
      if (push && (!full || pop)) mem[wr_ptr_reg[AW-1:0]] <= evt_next;
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         o_Overflow <= 1'b0;
      end else begin
         if (push && (!full || pop)) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (push && full && !pop) begin
            o_Overflow <= 1'b1;
         end else if (i_ClrOvf) begin
            o_Overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Directed bench for ps2_scan_ctrl with a behavioural PS2 register model and an event scoreboard.
module tb_ps2_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        w_en;
   logic [31:0] waddr;
   logic [31:0] wdata;
   logic        r_en;
   logic [31:0] raddr;
   logic [31:0] rdata = '0;
   logic        err;
   logic        evt_valid;
   logic [9:0]  evt_data;
   logic        evt_ready;
   logic        ovf;
   logic        clr_ovf;
   logic [7:0]  err_count;
   logic        busy;

   int vectors = 0;
   int errors  = 0;

   logic [9:0] exp_q[$];
   logic [7:0] rx_mem [256];
   int rx_wr   = 0;
   int rx_rd   = 0;
   int err_req = 0;
   int err_ack = 0;
   bit m_ext   = 1'b0;
   bit m_rel   = 1'b0;

   always #5 clk = ~clk;

   ps2_scan_ctrl #(.POLL_DIV(16), .FIFO_DEPTH(8)) dut (
      .i_Clk(clk), .i_Rst(rst), .i_Enable(enable),
      .o_WEnable(w_en), .o_WAddr(waddr), .o_WData(wdata),
      .o_REnable(r_en), .o_RAddr(raddr), .i_RData(rdata), .i_Err(err),
      .o_EvtValid(evt_valid), .o_EvtData(evt_data), .i_EvtReady(evt_ready),
      .o_Overflow(ovf), .i_ClrOvf(clr_ovf), .o_ErrCount(err_count), .o_Busy(busy)
   );

   // PS2 register model: answers one cycle after each read strobe.
   always @(posedge clk) begin
      if (r_en && raddr == 32'h4) begin
         rdata   <= {30'd0, err_req != err_ack, rx_wr != rx_rd};
         err_ack <= err_req;
      end else if (r_en && raddr == 32'h8) begin
         rdata <= {24'd0, rx_mem[rx_rd % 256]};
         if (rx_wr != rx_rd) rx_rd <= rx_rd + 1;
      end else begin
         rdata <= '0;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Queue a byte in the receiver; the fold model decides the expected event.
   task automatic feed(input logic [7:0] b, input bit expect_push);
      rx_mem[rx_wr % 256] = b;
      rx_wr++;
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_rel = 1'b1;
      else begin
         if (expect_push) exp_q.push_back({m_rel, m_ext, b});
         m_ext = 1'b0;
         m_rel = 1'b0;
      end
   endtask

   task automatic wait_read(input logic [31:0] addr, output int n);
      n = 0;
      do begin
         tick(1);
         n++;
      end while (!(r_en && raddr == addr) && n < 400);
      check("read_seen", r_en, 1'b1);
   endtask

   task automatic wait_write(input string tag, input logic [31:0] data, output int n);
      n = 0;
      do begin
         tick(1);
         n++;
      end while (!w_en && n < 400);
      check({tag, "_strobe"}, w_en, 1'b1);
      check({tag, "_addr"}, waddr, 32'h0);
      check({tag, "_data"}, wdata, data);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (rx_rd != rx_wr && n < 2000) begin
         tick(1);
         n++;
      end
      check("rx_drained", rx_rd == rx_wr, 1'b1);
   endtask

   task automatic expect_events();
      int t;
      logic [9:0] e;
      while (exp_q.size() > 0) begin
         t = 0;
         while (!evt_valid && t < 400) begin
            tick(1);
            t++;
         end
         e = exp_q.pop_front();
         check("evt_valid", evt_valid, 1'b1);
         check("evt_data", evt_data, e);
         if (!evt_valid) begin
            exp_q.delete();
         end else begin
            evt_ready = 1'b1;
            tick(1);
            evt_ready = 1'b0;
         end
      end
      check("evt_drained", evt_valid, 1'b0);
   endtask

   initial begin
      int n;
      logic [9:0] head;
      rst = 1'b1; enable = 1'b0; err = 1'b0; evt_ready = 1'b0; clr_ovf = 1'b0;
      tick(3);
      check("rst_wen", w_en, 1'b0);
      check("rst_ren", r_en, 1'b0);
      check("rst_valid", evt_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_errcnt", err_count, 8'd0);
      check("rst_ovf", ovf, 1'b0);
      $display("reset state checked");

      // Arm and poll cadence
      enable = 1'b1;
      tick(1);
      rst = 1'b0;
      wait_write("arm", 32'd1, n);
      check("arm_latency_le2", n <= 2, 1'b1);
      wait_read(32'h4, n);
      wait_read(32'h4, n);
      check("poll_period", n, 18);
      $display("arm: CTRL=1 written, poll period %0d", n);

      // Plain byte and latency
      tick(1);
      feed(8'h1C, 1'b1);
      wait_read(32'h4, n);
      tick(4);
      check("lat_not_yet", evt_valid, 1'b0);
      tick(1);
      check("lat_valid", evt_valid, 1'b1);
      check("lat_data", evt_data, 10'h01C);
      expect_events();
      $display("plain byte 1C -> event 01C");

      // Prefix folding
      feed(8'hE0, 1'b1); feed(8'hF0, 1'b1); feed(8'h75, 1'b1); feed(8'h75, 1'b1);
      expect_events();
      $display("prefix bytes E0 F0 75 75 folded");

      // Error recovery after an extended prefix
      feed(8'hE0, 1'b1);
      wait_drain();
      tick(4);
      err_req++;
      m_ext = 1'b0; m_rel = 1'b0;
      wait_write("err_dis", 32'd0, n);
      tick(1);
      check("err_en_strobe", w_en, 1'b1);
      check("err_en_data", wdata, 32'd1);
      check("err_count_1", err_count, 8'd1);
      feed(8'h1C, 1'b1);
      expect_events();
      $display("error recovery: CTRL=0 then CTRL=1, count %0d", err_count);

      // FIFO full, overflow, clear, simultaneous push/pop when full
      for (int i = 0; i < 8; i++) feed(8'(8'h10 + i), 1'b1);
      feed(8'h18, 1'b0);
      wait_drain();
      tick(4);
      check("ovf_set", ovf, 1'b1);
      check("full_valid", evt_valid, 1'b1);
      check("full_head", evt_data, exp_q[0]);
      clr_ovf = 1'b1;
      tick(1);
      clr_ovf = 1'b0;
      check("ovf_clr", ovf, 1'b0);
      feed(8'h19, 1'b0);
      wait_read(32'h8, n);
      tick(2);
      head = exp_q.pop_front();
      check("pushpop_head", evt_data, head);
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
      exp_q.push_back(10'h019);
      check("pushpop_no_ovf", ovf, 1'b0);
      expect_events();
      $display("fifo full: overflow flagged, push+pop when full kept all");

      // Disable during FETCH
      feed(8'h2A, 1'b1);
      wait_read(32'h8, n);
      enable = 1'b0;
      m_ext = 1'b0; m_rel = 1'b0;
      wait_write("dis", 32'd0, n);
      check("dis_latency", n, 4);
      tick(1);
      check("dis_busy", busy, 1'b0);
      expect_events();
      $display("disable during fetch: byte kept, CTRL=0, idle");

      // Error counter saturation
      enable = 1'b1;
      err = 1'b1;
      tick(6200);
      check("err_sat", err_count, 8'd255);
      err = 1'b0;
      m_ext = 1'b0; m_rel = 1'b0;
      $display("error counter saturated at %0d", err_count);

      // Reset while events are queued
      feed(8'h31, 1'b1); feed(8'h32, 1'b1); feed(8'h33, 1'b1);
      wait_drain();
      tick(6);
      check("pre_rst_valid", evt_valid, 1'b1);
      rst = 1'b1;
      tick(1);
      check("midrst_valid", evt_valid, 1'b0);
      check("midrst_errcnt", err_count, 8'd0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_wen", w_en, 1'b0);
      check("midrst_ovf", ovf, 1'b0);
      exp_q.delete();
      enable = 1'b0;
      rst = 1'b0;
      tick(2);
      check("post_rst_busy", busy, 1'b0);
      $display("reset mid-operation: queue flushed, counters cleared");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
